// File: rtl/adc_responder.sv
// SPI responder emulating a 2-channel, 10-bit MCP3002-style ADC.
// The SPI pins are oversampled on clk, and every state decision uses the synchronized copies.
module adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       mosi,
  input  logic [9:0] sample0,
  input  logic [9:0] sample1,
  output logic       miso,
  output logic       miso_en,
  output logic       busy,
  output logic       conv_done,
  output logic       frame_err,
  output logic [2:0] last_cmd
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CMD,
    ST_NULL,
    ST_DATA,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s, ncs_s, mosi_s;
  logic sclk_rise, sclk_fall;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic [9:0] shift_q, shift_d;
  logic       last_pend_q, last_pend_d;
  logic       miso_q, miso_d;
  logic       miso_en_q, miso_en_d;
  logic       busy_q, busy_d;
  logic       conv_done_q, conv_done_d;
  logic       frame_err_q, frame_err_d;
  logic [2:0] last_cmd_q, last_cmd_d;

  // The 11-bit difference is clamped to zero when its sign bit is set.
  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return diff[10] ? 10'd0 : diff[9:0];
  endfunction

  function automatic logic [9:0] select_result(input logic sgl, input logic odd,
                                               input logic [9:0] s0, input logic [9:0] s1);
    if (sgl) return odd ? s1 : s0;
    else if (odd) return sat_sub(s1, s0);
    else return sat_sub(s0, s1);
  endfunction

  // Input synchronizers and sclk edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    last_pend_d = last_pend_q;
    miso_d      = miso_q;
    miso_en_d   = miso_en_q;
    busy_d      = busy_q;
    conv_done_d = 1'b0;
    frame_err_d = 1'b0;
    last_cmd_d  = last_cmd_q;

    // A deselect overrides any sclk edge seen in the same cycle.
    if (ncs_s) begin
      if (state_q == ST_CMD || state_q == ST_NULL || state_q == ST_DATA)
        frame_err_d = 1'b1;
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      miso_en_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_START;
        ST_WAIT_START: begin
          if (sclk_rise && mosi_s) begin
            state_d = ST_CMD;
            busy_d  = 1'b1;
            cnt_d   = 4'd0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_d = {cmd_q[0], mosi_s};
            cnt_d = cnt_q + 4'd1;
            // cmd_q holds {SGL, ODD} here and mosi_s is MSBF.
            if (cnt_q == 4'd2) begin
              last_cmd_d = {cmd_q, mosi_s};
              shift_d    = select_result(cmd_q[1], cmd_q[0], sample0, sample1);
              state_d    = ST_NULL;
            end
          end
        end
        ST_NULL: begin
          if (sclk_fall) begin
            miso_en_d   = 1'b1;
            miso_d      = 1'b0;
            cnt_d       = 4'd9;
            last_pend_d = 1'b0;
            state_d     = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sclk_fall && !last_pend_q) begin
            miso_d = shift_q[cnt_q];
            if (cnt_q == 4'd0) last_pend_d = 1'b1;
            else cnt_d = cnt_q - 4'd1;
          end else if (sclk_rise && last_pend_q) begin
            state_d     = ST_DONE;
            conv_done_d = 1'b1;
            miso_d      = 1'b0;
          end
        end
        ST_DONE: miso_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state carries reset; the datapath is always loaded before it is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      last_cmd_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      frame_err_q <= frame_err_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q       <= cnt_d;
    cmd_q       <= cmd_d;
    shift_q     <= shift_d;
    last_pend_q <= last_pend_d;
  end

  assign miso      = miso_q;
  assign miso_en   = miso_en_q;
  assign busy      = busy_q;
  assign conv_done = conv_done_q;
  assign frame_err = frame_err_q;
  assign last_cmd  = last_cmd_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: a bit-banged SPI master drives frames,
// and a monitor compares each conv_done/frame_err event against queued expectations.
`timescale 1ns/1ps
module tb_adc_responder;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       ncs = 1'b1;
  logic       mosi = 1'b0;
  logic [9:0] sample0 = '0;
  logic [9:0] sample1 = '0;
  logic       miso, miso_en, busy, conv_done, frame_err;
  logic [2:0] last_cmd;

  typedef struct packed {
    logic       is_err;
    logic [9:0] data;
    logic [2:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  adc_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ncs(ncs), .mosi(mosi),
    .sample0(sample0), .sample1(sample1), .miso(miso), .miso_en(miso_en),
    .busy(busy), .conv_done(conv_done), .frame_err(frame_err), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clock_bit(input logic b);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] cmd);
    clock_bit(1'b1);
    for (int i = 2; i >= 0; i--) clock_bit(cmd[i]);
  endtask

  task automatic full_frame(input int lead, input logic [2:0] cmd, input logic [9:0] exp_data,
                            input logic chg, input logic [9:0] new_s0);
    exp_q.push_back('{is_err: 1'b0, data: exp_data, cmd: cmd});
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < lead; i++) clock_bit(1'b0);
    check("busy_before_start", busy, 0);
    send_cmd(cmd);
    check("busy_after_start", busy, 1);
    if (chg) sample0 = new_s0;
    repeat (11) clock_bit(1'b0);
    repeat (4) @(negedge clk);
    check("done_miso_en", miso_en, 1);
    check("done_miso", miso, 0);
    ncs = 1'b1;
    repeat (HALF) @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  // Monitor: captures miso on each master sclk rise and checks events
  initial begin
    logic       sclk_prev = 1'b0;
    logic       ncs_prev = 1'b1;
    logic [10:0] rx = '0;
    int         rx_n = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      #1;
      if (ncs_prev && !ncs) begin
        rx = '0;
        rx_n = 0;
      end
      if (sclk && !sclk_prev && miso_en) begin
        rx = {rx[9:0], miso};
        rx_n++;
      end
      if (conv_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_conv_done: got pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_conv", 0, e.is_err);
          check("null_bit", rx[10], 0);
          check("data", rx[9:0], e.data);
          check("bit_count", rx_n, 11);
          check("last_cmd", last_cmd, e.cmd);
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_err: got pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", 1, e.is_err);
          check("last_cmd_err", last_cmd, e.cmd);
        end
      end
      sclk_prev = sclk;
      ncs_prev = ncs;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_busy", busy, 0);
    check("rst_conv_done", conv_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_last_cmd", last_cmd, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single-ended CH0 and CH1
    sample0 = 10'h2A5;
    sample1 = 10'h0F0;
    full_frame(0, 3'b101, 10'h2A5, 1'b0, 10'h0);
    full_frame(0, 3'b111, 10'h0F0, 1'b0, 10'h0);

    // Differential, negative result clamps to zero
    sample0 = 10'h100;
    sample1 = 10'h180;
    full_frame(0, 3'b001, 10'h000, 1'b0, 10'h0);
    full_frame(0, 3'b011, 10'h080, 1'b0, 10'h0);

    // Leading zeros before the start bit
    sample0 = 10'h3FF;
    full_frame(3, 3'b101, 10'h3FF, 1'b0, 10'h0);

    // Abort after 4 data bits
    sample0 = 10'h2A5;
    sample1 = 10'h0F0;
    exp_q.push_back('{is_err: 1'b1, data: 10'h0, cmd: 3'b101});
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(3'b101);
    repeat (5) clock_bit(1'b0);
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    check("abort_miso_en", miso_en, 0);
    repeat (HALF) @(negedge clk);
    full_frame(0, 3'b111, 10'h0F0, 1'b0, 10'h0);

    // Abort inside the command leaves last_cmd untouched
    exp_q.push_back('{is_err: 1'b1, data: 10'h0, cmd: 3'b111});
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    clock_bit(1'b1);
    clock_bit(1'b0);
    clock_bit(1'b1);
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (HALF) @(negedge clk);

    // Reset during DATA
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(3'b101);
    repeat (4) clock_bit(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_en", miso_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last_cmd", last_cmd, 0);
    @(negedge clk);
    reset = 1'b0;
    ncs = 1'b1;
    repeat (HALF) @(negedge clk);

    // Sample change after the command latch does not affect the frame
    sample0 = 10'h155;
    full_frame(0, 3'b101, 10'h155, 1'b1, 10'h0AA);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
